apb_master_arbiter: RTL and testbench

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_rr_arbiter.sv | 29 ++
 rtl/apb_master_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared FSM state type and default bus widths for the APB master arbiter.
package apb_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: searches upward from the slot after the
// previous winner and returns a one-hot grant plus a valid flag.
module apb_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last_grant,
   output logic [NUM_REQ-1:0] o_grant_c,
   output logic               o_valid_c
);

   int unsigned w_idx;

   // Walk the ring starting one past the last winner; first requester found wins.
   always_comb begin
      o_grant_c = '0;
      o_valid_c = 1'b0;
      w_idx     = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_idx = (32'(i_last_grant) + k) % NUM_REQ;
         if (!o_valid_c && i_req[IDX_W'(w_idx)]) begin
            o_grant_c[IDX_W'(w_idx)] = 1'b1;
            o_valid_c                = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters with round-robin
// arbitration, wait-state handling and an ACCESS-phase timeout.
module apb_master_arbiter
   import apb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned TIMEOUT = 16
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
   input  logic [NUM_REQ-1:0]         req_write,
   output logic [NUM_REQ-1:0]         done,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       rsp_err,
   output logic                       psel,
   output logic                       penable,
   output logic [ADDR_W-1:0]          paddr,
   output logic                       pwrite,
   output logic [DATA_W-1:0]          pwdata,
   input  logic [DATA_W-1:0]          prdata,
   input  logic                       pready,
   input  logic                       pslverr
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   apb_state_e          r_state,       w_state_nxt;
   logic                r_psel,        w_psel_nxt;
   logic                r_penable,     w_penable_nxt;
   logic [ADDR_W-1:0]   r_paddr,       w_paddr_nxt;
   logic                r_pwrite,      w_pwrite_nxt;
   logic [DATA_W-1:0]   r_pwdata,      w_pwdata_nxt;
   logic [NUM_REQ-1:0]  r_done,        w_done_nxt;
   logic [DATA_W-1:0]   r_rsp_rdata,   w_rsp_rdata_nxt;
   logic                r_rsp_err,     w_rsp_err_nxt;
   logic [CNT_W-1:0]    r_wait_cnt,    w_wait_cnt_nxt;
   logic [IDX_W-1:0]    r_last_grant,  w_last_grant_nxt;

   logic [NUM_REQ-1:0]  w_req_masked;
   logic [NUM_REQ-1:0]  w_grant;
   logic                w_grant_valid;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic                w_sel_write;
   logic [IDX_W-1:0]    w_sel_idx;

   // A requester whose done pulse is showing cannot win again in that cycle.
   assign w_req_masked = req & ~r_done;

   apb_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .i_req        (w_req_masked),
      .i_last_grant (r_last_grant),
      .o_grant_c    (w_grant),
      .o_valid_c    (w_grant_valid)
   );

   // Mux the winning requester's transfer fields and index.
   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_write = 1'b0;
      w_sel_idx   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            w_sel_write = req_write[i];
            w_sel_idx   = IDX_W'(i);
         end
      end
   end

   // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequence.
   always_comb begin
      w_state_nxt      = r_state;
      w_psel_nxt       = r_psel;
      w_penable_nxt    = r_penable;
      w_paddr_nxt      = r_paddr;
      w_pwrite_nxt     = r_pwrite;
      w_pwdata_nxt     = r_pwdata;
      w_done_nxt       = '0;
      w_rsp_rdata_nxt  = r_rsp_rdata;
      w_rsp_err_nxt    = r_rsp_err;
      w_wait_cnt_nxt   = r_wait_cnt;
      w_last_grant_nxt = r_last_grant;

      case (r_state)
         ST_IDLE: begin
            w_psel_nxt     = 1'b0;
            w_penable_nxt  = 1'b0;
            w_wait_cnt_nxt = '0;
            if (w_grant_valid) begin
               w_state_nxt      = ST_SETUP;
               w_psel_nxt       = 1'b1;
               w_paddr_nxt      = w_sel_addr;
               w_pwdata_nxt     = w_sel_wdata;
               w_pwrite_nxt     = w_sel_write;
               w_last_grant_nxt = w_sel_idx;
            end
         end

         ST_SETUP: begin
            w_state_nxt    = ST_ACCESS;
            w_psel_nxt     = 1'b1;
            w_penable_nxt  = 1'b1;
            w_wait_cnt_nxt = '0;
         end

         ST_ACCESS: begin
            if (pready) begin
               // Completion wins even on the final allowed ACCESS cycle.
               w_state_nxt              = ST_IDLE;
               w_psel_nxt               = 1'b0;
               w_penable_nxt            = 1'b0;
               w_wait_cnt_nxt           = '0;
               w_rsp_err_nxt            = pslverr;
               w_done_nxt[r_last_grant] = 1'b1;
               if (!r_pwrite) begin
                  w_rsp_rdata_nxt = prdata;
               end
            end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_state_nxt              = ST_IDLE;
               w_psel_nxt               = 1'b0;
               w_penable_nxt            = 1'b0;
               w_wait_cnt_nxt           = '0;
               w_rsp_err_nxt            = 1'b1;
               w_rsp_rdata_nxt          = '0;
               w_done_nxt[r_last_grant] = 1'b1;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
            end
         end

         default: begin
            w_state_nxt   = ST_IDLE;
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops the bus immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_psel       <= 1'b0;
         r_penable    <= 1'b0;
         r_paddr      <= '0;
         r_pwrite     <= 1'b0;
         r_pwdata     <= '0;
         r_done       <= '0;
         r_rsp_rdata  <= '0;
         r_rsp_err    <= 1'b0;
         r_wait_cnt   <= '0;
         r_last_grant <= IDX_W'(NUM_REQ - 1);
      end else begin
         r_state      <= w_state_nxt;
         r_psel       <= w_psel_nxt;
         r_penable    <= w_penable_nxt;
         r_paddr      <= w_paddr_nxt;
         r_pwrite     <= w_pwrite_nxt;
         r_pwdata     <= w_pwdata_nxt;
         r_done       <= w_done_nxt;
         r_rsp_rdata  <= w_rsp_rdata_nxt;
         r_rsp_err    <= w_rsp_err_nxt;
         r_wait_cnt   <= w_wait_cnt_nxt;
         r_last_grant <= w_last_grant_nxt;
      end
   end

   assign psel      = r_psel;
   assign penable   = r_penable;
   assign paddr     = r_paddr;
   assign pwrite    = r_pwrite;
   assign pwdata    = r_pwdata;
   assign done      = r_done;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus a randomized run
// against a transfer-level model (round-robin order, slave wait states).
module tb_apb_master_arbiter;

   localparam int NR  = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [NR-1:0]    req = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [NR-1:0]    req_write = '0;
   logic [NR-1:0]    done;
   logic [DW-1:0]    rsp_rdata;
   logic             rsp_err;
   logic             psel;
   logic             penable;
   logic [AW-1:0]    paddr;
   logic             pwrite;
   logic [DW-1:0]    pwdata;
   logic [DW-1:0]    prdata = '0;
   logic             pready = 1'b0;
   logic             pslverr = 1'b0;

   int checks = 0;
   int errors = 0;

   apb_master_arbiter #(
      .NUM_REQ (NR),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_write (req_write),
      .done      (done),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .paddr     (paddr),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   always #5 clk = ~clk;

   // Round-robin rule: first requester found searching upward from last+1.
   function automatic int rr_pick(input logic [NR-1:0] v, input int last);
      for (int k = 1; k <= NR; k++) begin
         if (v[(last + k) % NR]) return (last + k) % NR;
      end
      return -1;
   endfunction

   task automatic new_txn(input int i);
      req_addr[i*AW +: AW]  = $urandom & 32'hFFFF_FFFC;
      req_wdata[i*DW +: DW] = $urandom;
      req_write[i]          = 1'($urandom_range(0, 1));
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({psel, penable, pwrite, rsp_err} !== 4'b0 || done !== '0) begin
         errors++;
         $display("FAIL reset_ctrl psel=%b penable=%b pwrite=%b rsp_err=%b done=%b required all 0",
                  psel, penable, pwrite, rsp_err, done);
      end
      checks++;
      if (paddr !== '0 || pwdata !== '0 || rsp_rdata !== '0) begin
         errors++;
         $display("FAIL reset_data paddr=%h pwdata=%h rsp_rdata=%h required 0", paddr, pwdata, rsp_rdata);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_write();
      @(negedge clk);
      req_addr[0*AW +: AW]  = 32'h10;
      req_wdata[0*DW +: DW] = 32'hA5A5_0001;
      req_write[0] = 1'b1;
      req[0]  = 1'b1;
      pready  = 1'b1;
      pslverr = 1'b0;
      @(negedge clk);
      checks++;
      if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h10 || pwrite !== 1'b1 || pwdata !== 32'hA5A5_0001) begin
         errors++;
         $display("FAIL wr_setup psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h required 1 0 00000010 1 a5a50001",
                  psel, penable, paddr, pwrite, pwdata);
      end
      @(negedge clk);
      checks++;
      if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 32'h10) begin
         errors++;
         $display("FAIL wr_access psel=%b penable=%b paddr=%h required 1 1 00000010", psel, penable, paddr);
      end
      @(negedge clk);
      checks++;
      if (done !== 4'b0001 || rsp_err !== 1'b0 || psel !== 1'b0 || penable !== 1'b0) begin
         errors++;
         $display("FAIL wr_done done=%b rsp_err=%b psel=%b penable=%b required 0001 0 0 0", done, rsp_err, psel, penable);
      end
      req[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 4'b0 || psel !== 1'b0) begin
         errors++;
         $display("FAIL wr_after done=%b psel=%b required 0000 0", done, psel);
      end
   endtask

   task automatic test_read_wait();
      @(negedge clk);
      req_addr[2*AW +: AW] = 32'h20;
      req_write[2] = 1'b0;
      req[2]  = 1'b1;
      pready  = 1'b0;
      prdata  = 32'hDEAD_BEEF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (psel !== 1'b1 || paddr !== 32'h20 || pwrite !== 1'b0 || penable !== (c != 0)) begin
            errors++;
            $display("FAIL rd_stable cycle=%0d psel=%b penable=%b paddr=%h pwrite=%b required 1 %0d 00000020 0",
                     c, psel, penable, paddr, pwrite, (c != 0));
         end
         if (c == 3) pready = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (done !== 4'b0100 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0 || psel !== 1'b0) begin
         errors++;
         $display("FAIL rd_done done=%b rdata=%h err=%b psel=%b required 0100 deadbeef 0 0", done, rsp_rdata, rsp_err, psel);
      end
      req[2] = 1'b0;
      pready = 1'b0;
   endtask

   task automatic test_slverr();
      @(negedge clk);
      req_addr[3*AW +: AW]  = 32'h30;
      req_wdata[3*DW +: DW] = 32'h0000_1234;
      req_write[3] = 1'b1;
      req[3]  = 1'b1;
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = 32'h0BAD_0BAD;
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 4'b1000 || rsp_err !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL slverr_done done=%b err=%b rdata=%h required 1000 1 deadbeef", done, rsp_err, rsp_rdata);
      end
      req[3]  = 1'b0;
      pslverr = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int n_g;
      int cyc;
      int last_cyc;
      int g;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AW +: AW] = 32'((i + 1) * 256);
         req_write[i] = 1'b0;
      end
      pready = 1'b1;
      prdata = 32'hCAFE_0000;
      req    = 4'hF;
      n_g = 0;
      cyc = 0;
      last_cyc = 0;
      while (n_g < 5 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (psel && !penable) begin
            g = int'(paddr[11:8]) - 1;
            checks++;
            if (g !== n_g % NR) begin
               errors++;
               $display("FAIL rr_order grant#%0d got requester %0d required %0d", n_g, g, n_g % NR);
            end
            if (n_g > 0) begin
               checks++;
               if (cyc - last_cyc != 3) begin
                  errors++;
                  $display("FAIL rr_period grant#%0d spacing %0d cycles required 3", n_g, cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            n_g++;
         end
      end
      checks++;
      if (n_g < 5) begin
         errors++;
         $display("FAIL rr_budget grants seen %0d required 5", n_g);
      end
      req = '0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_timeout();
      int acc;
      int cyc;
      int n_done;
      @(negedge clk);
      req_addr[1*AW +: AW] = 32'h300;
      req_write[1] = 1'b0;
      req[1]  = 1'b1;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'h1234_5678;
      acc = 0;
      cyc = 0;
      n_done = 0;
      while (cyc < 40 && n_done == 0) begin
         @(negedge clk);
         cyc++;
         if (psel && penable) acc++;
         if (done !== '0) begin
            n_done++;
            checks++;
            if (done !== 4'b0010 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || acc != TMO || psel !== 1'b0) begin
               errors++;
               $display("FAIL tmo_done done=%b err=%b rdata=%h access_cycles=%0d psel=%b required 0010 1 00000000 %0d 0",
                        done, rsp_err, rsp_rdata, acc, psel, TMO);
            end
            req[1] = 1'b0;
         end
      end
      checks++;
      if (n_done == 0) begin
         errors++;
         $display("FAIL tmo_budget no done within 40 cycles, access_cycles=%0d required done after %0d", acc, TMO);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (done !== '0 || psel !== 1'b0) begin
            errors++;
            $display("FAIL tmo_after done=%b psel=%b required 0000 0", done, psel);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_addr[1*AW +: AW] = 32'h44;
      req_write[1] = 1'b0;
      req[1] = 1'b1;
      pready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (psel !== 1'b1 || penable !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_access psel=%b penable=%b required 1 1", psel, penable);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (psel !== 1'b0 || penable !== 1'b0 || done !== '0) begin
         errors++;
         $display("FAIL rstmid_async psel=%b penable=%b done=%b required 0 0 0000", psel, penable, done);
      end
      @(negedge clk);
      req = '0;
      pready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (done !== '0 || psel !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_nodone done=%b psel=%b required 0000 0", done, psel);
         end
      end
      req_addr[0*AW +: AW] = 32'h500;
      req_addr[2*AW +: AW] = 32'h700;
      req[0] = 1'b1;
      req[2] = 1'b1;
      @(negedge clk);
      checks++;
      if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h500) begin
         errors++;
         $display("FAIL rstmid_first psel=%b penable=%b paddr=%h required 1 0 00000500", psel, penable, paddr);
      end
      req = '0;
      repeat (4) @(negedge clk);
      pready = 1'b0;
   endtask

   task automatic test_random();
      int last_g, cur, w, acc, cyc, g, tot;
      int left[NR];
      int gap[NR];
      bit in_xfer, exp_done, exp_err, x_err, x_wr, psel_prev, busy;
      logic [31:0] x_addr, x_wdata, x_rdata, exp_rdata, model_rdata;
      logic [NR-1:0] elig_prev, oh;

      req = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      last_g = NR - 1;
      model_rdata = '0;
      exp_rdata = '0;
      exp_err = 1'b0;
      in_xfer = 1'b0;
      exp_done = 1'b0;
      psel_prev = 1'b0;
      elig_prev = '0;
      cur = 0; w = 0; acc = 0; x_err = 1'b0; x_wr = 1'b0;
      x_addr = '0; x_wdata = '0; x_rdata = '0;
      for (int i = 0; i < NR; i++) begin
         left[i] = 10;
         gap[i]  = $urandom_range(1, 4);
      end
      cyc = 0;
      busy = 1'b1;
      while (busy && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         oh = '0;
         oh[cur] = 1'b1;
         if (exp_done) begin
            checks++;
            if (done !== oh || rsp_rdata !== exp_rdata || rsp_err !== exp_err || psel !== 1'b0) begin
               errors++;
               $display("FAIL rnd_done cyc=%0d done=%b rdata=%h err=%b psel=%b required %b %h %b 0",
                        cyc, done, rsp_rdata, rsp_err, psel, oh, exp_rdata, exp_err);
            end
            exp_done = 1'b0;
            in_xfer  = 1'b0;
            left[cur]--;
            if (left[cur] > 0 && $urandom_range(0, 1) == 1) begin
               new_txn(cur);
            end else begin
               req[cur] = 1'b0;
               gap[cur] = $urandom_range(1, 4);
            end
         end else begin
            checks++;
            if (done !== '0) begin
               errors++;
               $display("FAIL rnd_spurious_done cyc=%0d done=%b required 0000", cyc, done);
            end
         end

         if (psel && !penable) begin
            g = rr_pick(elig_prev, last_g);
            checks++;
            if (psel_prev || g < 0) begin
               errors++;
               $display("FAIL rnd_setup cyc=%0d setup with psel_prev=%b eligible=%b required idle with a request",
                        cyc, psel_prev, elig_prev);
            end else begin
               x_addr  = req_addr[g*AW +: AW];
               x_wdata = req_wdata[g*DW +: DW];
               x_wr    = req_write[g];
               checks++;
               if (paddr !== x_addr || pwrite !== x_wr || pwdata !== x_wdata) begin
                  errors++;
                  $display("FAIL rnd_grant cyc=%0d paddr=%h pwrite=%b pwdata=%h required requester %0d: %h %b %h",
                           cyc, paddr, pwrite, pwdata, g, x_addr, x_wr, x_wdata);
               end
               cur = g;
               last_g = g;
               in_xfer = 1'b1;
               acc = 0;
               case ($urandom_range(0, 19))
                  14, 15:  w = TMO - 1;
                  16:      w = TMO - 2;
                  17:      w = 1000;
                  default: w = $urandom_range(0, 3);
               endcase
               x_rdata = $urandom;
               x_err   = ($urandom_range(0, 3) == 0);
            end
         end else if (psel && penable) begin
            acc++;
            checks++;
            if (!in_xfer || paddr !== x_addr || pwrite !== x_wr || pwdata !== x_wdata) begin
               errors++;
               $display("FAIL rnd_access cyc=%0d in_xfer=%b paddr=%h pwrite=%b pwdata=%h required %h %b %h",
                        cyc, in_xfer, paddr, pwrite, pwdata, x_addr, x_wr, x_wdata);
            end
         end else begin
            checks++;
            if (in_xfer || penable !== 1'b0 || (!psel_prev && elig_prev != '0)) begin
               errors++;
               $display("FAIL rnd_idle cyc=%0d in_xfer=%b penable=%b psel_prev=%b eligible=%b required no stall",
                        cyc, in_xfer, penable, psel_prev, elig_prev);
            end
         end

         if (psel && penable && in_xfer) begin
            if (acc > w) begin
               pready  = 1'b1;
               pslverr = x_err;
               prdata  = x_rdata;
            end else begin
               pready  = 1'b0;
               pslverr = 1'($urandom_range(0, 1));
               prdata  = $urandom;
            end
            if (acc == w + 1) begin
               exp_done    = 1'b1;
               exp_err     = x_err;
               exp_rdata   = x_wr ? model_rdata : x_rdata;
               model_rdata = exp_rdata;
            end else if (acc == TMO) begin
               exp_done    = 1'b1;
               exp_err     = 1'b1;
               exp_rdata   = '0;
               model_rdata = '0;
            end
         end else begin
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
         end

         for (int i = 0; i < NR; i++) begin
            if (!req[i] && left[i] > 0) begin
               if (gap[i] > 0) gap[i]--;
               if (gap[i] == 0) begin
                  new_txn(i);
                  req[i] = 1'b1;
               end
            end
         end

         elig_prev = req & ~done;
         psel_prev = psel;
         tot = 0;
         for (int i = 0; i < NR; i++) tot += left[i];
         busy = (tot > 0) || in_xfer || exp_done;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL rnd_budget transfers outstanding after %0d cycles, required all complete", cyc);
      end
      req = '0;
      pready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_wait();
      test_slverr();
      test_round_robin();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
